// File: rtl/vend_dispense_controller.sv
// Vending dispense controller: coin credit, product dispense and change
// payout handshakes, with a sticky timeout fault. All outputs are registered.
module vend_dispense_controller #(
  parameter int PRICE_A     = 15,
  parameter int PRICE_B     = 20,
  parameter int MAX_CREDIT  = 35,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic [1:0] sel,
  output logic       disp_req,
  output logic       disp_id,
  input  logic       disp_ack,
  output logic       chg_req,
  output logic       chg_coin,
  input  logic       chg_ack,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic       busy,
  output logic       fault
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CREDIT   = 3'd1;
  localparam logic [2:0] S_DISPENSE = 3'd2;
  localparam logic [2:0] S_CHANGE   = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  localparam int         CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [5:0] P_A     = 6'(PRICE_A);
  localparam logic [5:0] P_B     = 6'(PRICE_B);
  localparam logic [6:0] MAX_C   = 7'(MAX_CREDIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [5:0]    r_credit;
  logic          r_disp_req;
  logic          r_disp_id;
  logic          r_chg_req;
  logic          r_chg_coin;
  logic          r_coin_reject;
  logic          r_busy;
  logic          r_fault;
  logic [CW-1:0] r_wait_cnt;

  logic [2:0]    w_state;
  logic [5:0]    w_credit;
  logic          w_disp_req;
  logic          w_disp_id;
  logic          w_chg_req;
  logic          w_chg_coin;
  logic          w_coin_reject;
  logic          w_busy;
  logic          w_fault;
  logic [CW-1:0] w_wait_cnt;
  logic [5:0]    w_coin_val;
  logic [6:0]    w_sum;
  logic [5:0]    w_chg_val;

  // Decode the inserted coin value and the tentative new credit.
  always_comb begin
    w_coin_val = 6'd0;
    case (coin)
      2'b01:   w_coin_val = 6'd5;
      2'b10:   w_coin_val = 6'd10;
      default: w_coin_val = 6'd0;
    endcase
    w_sum     = {1'b0, r_credit} + {1'b0, w_coin_val};
    w_chg_val = r_chg_coin ? 6'd10 : 6'd5;
  end

  // Next-state and next-output logic for the controller FSM.
  always_comb begin
    w_state       = r_state;
    w_credit      = r_credit;
    w_disp_req    = r_disp_req;
    w_disp_id     = r_disp_id;
    w_chg_req     = r_chg_req;
    w_chg_coin    = r_chg_coin;
    w_coin_reject = 1'b0;
    w_fault       = r_fault;
    w_wait_cnt    = r_wait_cnt;
    case (r_state)
      S_IDLE, S_CREDIT: begin
        // A coin is only accepted when no selection competes with it.
        w_coin_reject = (coin != 2'b00) &&
                        ((sel != 2'b00) || (coin == 2'b11) || (w_sum > MAX_C));
        if ((sel == 2'b01) && (r_credit >= P_A)) begin
          w_credit   = r_credit - P_A;
          w_disp_id  = 1'b0;
          w_disp_req = 1'b1;
          w_wait_cnt = '0;
          w_state    = S_DISPENSE;
        end else if ((sel == 2'b10) && (r_credit >= P_B)) begin
          w_credit   = r_credit - P_B;
          w_disp_id  = 1'b1;
          w_disp_req = 1'b1;
          w_wait_cnt = '0;
          w_state    = S_DISPENSE;
        end else if ((sel == 2'b11) && (r_credit != 6'd0)) begin
          w_chg_req  = 1'b1;
          w_chg_coin = (r_credit >= 6'd10);
          w_wait_cnt = '0;
          w_state    = S_CHANGE;
        end else if ((sel == 2'b00) && (w_coin_val != 6'd0) && (w_sum <= MAX_C)) begin
          w_credit = w_sum[5:0];
          w_state  = S_CREDIT;
        end else begin
          w_state = r_state;
        end
      end
      S_DISPENSE: begin
        w_coin_reject = (coin != 2'b00);
        if (disp_ack) begin
          w_disp_req = 1'b0;
          if (r_credit != 6'd0) begin
            w_chg_req  = 1'b1;
            w_chg_coin = (r_credit >= 6'd10);
            w_wait_cnt = '0;
            w_state    = S_CHANGE;
          end else begin
            w_state = S_IDLE;
          end
        end else if (r_wait_cnt == CNT_LAST) begin
          w_disp_req = 1'b0;
          w_fault    = 1'b1;
          w_state    = S_FAULT;
        end else begin
          w_wait_cnt = r_wait_cnt + CW'(1);
        end
      end
      S_CHANGE: begin
        w_coin_reject = (coin != 2'b00);
        if (r_chg_req) begin
          if (chg_ack) begin
            // Drop the request for one cycle between paid coins.
            w_chg_req = 1'b0;
            w_credit  = r_credit - w_chg_val;
            if (r_credit == w_chg_val) begin
              w_state = S_IDLE;
            end else begin
              w_state = S_CHANGE;
            end
          end else if (r_wait_cnt == CNT_LAST) begin
            w_chg_req = 1'b0;
            w_fault   = 1'b1;
            w_state   = S_FAULT;
          end else begin
            w_wait_cnt = r_wait_cnt + CW'(1);
          end
        end else begin
          w_chg_req  = 1'b1;
          w_chg_coin = (r_credit >= 6'd10);
          w_wait_cnt = '0;
        end
      end
      S_FAULT: begin
        w_coin_reject = (coin != 2'b00);
        w_disp_req    = 1'b0;
        w_chg_req     = 1'b0;
        w_fault       = 1'b1;
      end
      default: begin
        w_state    = S_IDLE;
        w_credit   = 6'd0;
        w_disp_req = 1'b0;
        w_chg_req  = 1'b0;
      end
    endcase
    w_busy = (w_state == S_DISPENSE) || (w_state == S_CHANGE) || (w_state == S_FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= 6'd0;
      r_disp_req    <= 1'b0;
      r_disp_id     <= 1'b0;
      r_chg_req     <= 1'b0;
      r_chg_coin    <= 1'b0;
      r_coin_reject <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_state       <= w_state;
      r_credit      <= w_credit;
      r_disp_req    <= w_disp_req;
      r_disp_id     <= w_disp_id;
      r_chg_req     <= w_chg_req;
      r_chg_coin    <= w_chg_coin;
      r_coin_reject <= w_coin_reject;
      r_busy        <= w_busy;
      r_fault       <= w_fault;
      r_wait_cnt    <= w_wait_cnt;
    end
  end

  assign disp_req    = r_disp_req;
  assign disp_id     = r_disp_id;
  assign chg_req     = r_chg_req;
  assign chg_coin    = r_chg_coin;
  assign coin_reject = r_coin_reject;
  assign credit      = r_credit;
  assign busy        = r_busy;
  assign fault       = r_fault;

endmodule

// File: tb/tb_vend_dispense_controller.sv
// Directed, table-driven bench for vend_dispense_controller.
module tb_vend_dispense_controller;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       disp_req;
  logic       disp_id;
  logic       disp_ack;
  logic       chg_req;
  logic       chg_coin;
  logic       chg_ack;
  logic       coin_reject;
  logic [5:0] credit;
  logic       busy;
  logic       fault;

  int n_checks;
  int n_errors;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       dack;
    logic       cack;
    logic [5:0] e_credit;
    logic       e_dreq;
    logic       e_did;
    logic       e_creq;
    logic       e_ccoin;
    logic       e_rej;
    logic       e_busy;
    logic       e_fault;
  } vec_t;

  vec_t vecs[$];

  vend_dispense_controller #(
    .PRICE_A(15), .PRICE_B(20), .MAX_CREDIT(35), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel),
    .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .coin_reject(coin_reject), .credit(credit), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic [1:0] c, input logic [1:0] s,
                     input logic da, input logic ca, input logic [5:0] ecr, input logic edr,
                     input logic edi, input logic ecq, input logic ecc, input logic erj,
                     input logic eb, input logic ef);
    vec_t v;
    v.name = name; v.rst = r; v.coin = c; v.sel = s; v.dack = da; v.cack = ca;
    v.e_credit = ecr; v.e_dreq = edr; v.e_did = edi; v.e_creq = ecq; v.e_ccoin = ecc;
    v.e_rej = erj; v.e_busy = eb; v.e_fault = ef;
    vecs.push_back(v);
  endtask

  // Apply one cycle of inputs and sample outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic [1:0] c, input logic [1:0] s,
                      input logic da, input logic ca);
    rst = r; coin = c; sel = s; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    #1;
  endtask

  // disp_id / chg_coin are only meaningful while their request is high.
  task automatic check(input string name, input logic [5:0] ecr, input logic edr, input logic edi,
                       input logic ecq, input logic ecc, input logic erj, input logic eb,
                       input logic ef);
    logic bad;
    bad = (credit !== ecr) || (disp_req !== edr) || (edr && (disp_id !== edi)) ||
          (chg_req !== ecq) || (ecq && (chg_coin !== ecc)) || (coin_reject !== erj) ||
          (busy !== eb) || (fault !== ef);
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL %s: got credit=%0d dreq=%b did=%b creq=%b ccoin=%b rej=%b busy=%b fault=%b, expected credit=%0d dreq=%b did=%b creq=%b ccoin=%b rej=%b busy=%b fault=%b",
               name, credit, disp_req, disp_id, chg_req, chg_coin, coin_reject, busy, fault,
               ecr, edr, edi, ecq, ecc, erj, eb, ef);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; coin = 2'b00; sel = 2'b00; disp_ack = 1'b0; chg_ack = 1'b0;

    //   name           rst coin   sel    da ca  credit dreq did creq ccoin rej busy fault
    add("reset",        1, 2'b00, 2'b00, 0, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("a_coin5_1",    0, 2'b01, 2'b00, 0, 0, 6'd5,  0, 0, 0, 0, 0, 0, 0);
    add("a_coin5_2",    0, 2'b01, 2'b00, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0, 0);
    add("a_coin5_3",    0, 2'b01, 2'b00, 0, 0, 6'd15, 0, 0, 0, 0, 0, 0, 0);
    add("a_sel_a",      0, 2'b00, 2'b01, 0, 0, 6'd0,  1, 0, 0, 0, 0, 1, 0);
    add("a_hold",       0, 2'b00, 2'b00, 0, 0, 6'd0,  1, 0, 0, 0, 0, 1, 0);
    add("a_ack",        0, 2'b00, 2'b00, 1, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("a_idle",       0, 2'b00, 2'b00, 0, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("b_coin10_1",   0, 2'b10, 2'b00, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0, 0);
    add("b_coin10_2",   0, 2'b10, 2'b00, 0, 0, 6'd20, 0, 0, 0, 0, 0, 0, 0);
    add("b_coin10_3",   0, 2'b10, 2'b00, 0, 0, 6'd30, 0, 0, 0, 0, 0, 0, 0);
    add("b_sel_b",      0, 2'b00, 2'b10, 0, 0, 6'd10, 1, 1, 0, 0, 0, 1, 0);
    add("b_dack",       0, 2'b00, 2'b00, 1, 0, 6'd10, 0, 0, 1, 1, 0, 1, 0);
    add("b_cack",       0, 2'b00, 2'b00, 0, 1, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("c_coin10_1",   0, 2'b10, 2'b00, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0, 0);
    add("c_coin10_2",   0, 2'b10, 2'b00, 0, 0, 6'd20, 0, 0, 0, 0, 0, 0, 0);
    add("c_coin10_3",   0, 2'b10, 2'b00, 0, 0, 6'd30, 0, 0, 0, 0, 0, 0, 0);
    add("c_over_max",   0, 2'b10, 2'b00, 0, 0, 6'd30, 0, 0, 0, 0, 1, 0, 0);
    add("c_rej_1cyc",   0, 2'b00, 2'b00, 0, 0, 6'd30, 0, 0, 0, 0, 0, 0, 0);
    add("c_reset",      1, 2'b00, 2'b00, 0, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("c_illegal",    0, 2'b11, 2'b00, 0, 0, 6'd0,  0, 0, 0, 0, 1, 0, 0);
    add("c_after_ill",  0, 2'b00, 2'b00, 0, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("d_coin10_1",   0, 2'b10, 2'b00, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0, 0);
    add("d_coin10_2",   0, 2'b10, 2'b00, 0, 0, 6'd20, 0, 0, 0, 0, 0, 0, 0);
    add("d_coin5",      0, 2'b01, 2'b00, 0, 0, 6'd25, 0, 0, 0, 0, 0, 0, 0);
    add("d_cancel",     0, 2'b00, 2'b11, 0, 0, 6'd25, 0, 0, 1, 1, 0, 1, 0);
    add("d_coin_busy",  0, 2'b01, 2'b00, 0, 0, 6'd25, 0, 0, 1, 1, 1, 1, 0);
    add("d_ack1",       0, 2'b00, 2'b00, 0, 1, 6'd15, 0, 0, 0, 0, 0, 1, 0);
    add("d_gap_ack_ign",0, 2'b00, 2'b00, 0, 1, 6'd15, 0, 0, 1, 1, 0, 1, 0);
    add("d_ack2",       0, 2'b00, 2'b00, 0, 1, 6'd5,  0, 0, 0, 0, 0, 1, 0);
    add("d_req3",       0, 2'b00, 2'b00, 0, 0, 6'd5,  0, 0, 1, 0, 0, 1, 0);
    add("d_ack3",       0, 2'b00, 2'b00, 0, 1, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("d_idle",       0, 2'b00, 2'b00, 0, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("e_coin10",     0, 2'b10, 2'b00, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0, 0);
    add("e_sel_low",    0, 2'b00, 2'b01, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0, 0);
    add("e_coin_and_cx",0, 2'b01, 2'b11, 0, 0, 6'd10, 0, 0, 1, 1, 1, 1, 0);
    add("e_refund_ack", 0, 2'b00, 2'b00, 0, 1, 6'd0,  0, 0, 0, 0, 0, 0, 0);
    add("e_dack_ign",   0, 2'b00, 2'b00, 1, 0, 6'd0,  0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].coin, vecs[i].sel, vecs[i].dack, vecs[i].cack);
      check(vecs[i].name, vecs[i].e_credit, vecs[i].e_dreq, vecs[i].e_did, vecs[i].e_creq,
            vecs[i].e_ccoin, vecs[i].e_rej, vecs[i].e_busy, vecs[i].e_fault);
    end

    // Dispense timeout: request stays up for 15 cycles, then FAULT.
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    check("f_credit20", 6'd20, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    check("f_disp_start", 6'd5, 1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      check($sformatf("f_wait_%0d", k), 6'd5, 1, 0, 0, 0, 0, 1, 0);
    end
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    check("f_timeout", 6'd5, 0, 0, 0, 0, 0, 1, 1);
    step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    check("f_coin_rej", 6'd5, 0, 0, 0, 0, 1, 1, 1);
    step(1'b0, 2'b00, 2'b11, 1'b1, 1'b1);
    check("f_ignore_all", 6'd5, 0, 0, 0, 0, 0, 1, 1);
    step(1'b1, 2'b10, 2'b01, 1'b0, 1'b0);
    check("f_reset", 6'd0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    check("f_post_reset", 6'd0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a change payout abandons it.
    step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
    check("g_change", 6'd10, 0, 0, 1, 1, 0, 1, 0);
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    check("g_reset", 6'd0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    check("g_no_req", 6'd0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
